sram_pipelined_controller: RTL and testbench

SRAM_PIPELINED_CONTROLLER -- requirements
Module: sram_pipelined_controller

---
 rtl/sram_pipelined_controller.sv | 155 +++++++++++++++
 tb/tb_sram_pipelined_controller.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_pipelined_controller.sv
// Avalon-MM slave to asynchronous SRAM bridge: one command in flight, registered pins,
// programmable read wait states, sticky flag for simultaneous read/write requests.
module sram_pipelined_controller #(
  parameter  int ADDR_WIDTH       = 20,
  parameter  int DATA_WIDTH       = 16,
  parameter  int READ_WAIT_CYCLES = 1,
  localparam int BE_WIDTH         = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] mm_address,
  input  logic                  mm_read,
  input  logic                  mm_write,
  input  logic [BE_WIDTH-1:0]   mm_byteenable,
  input  logic [DATA_WIDTH-1:0] mm_writedata,
  output logic                  mm_waitrequest,
  output logic [DATA_WIDTH-1:0] mm_readdata,
  output logic                  mm_readdatavalid,
  output logic                  mm_protocol_error,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [DATA_WIDTH-1:0] sram_dq,
  output logic [BE_WIDTH-1:0]   sram_be_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  sram_ce_n
);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] dq_out_q, dq_out_d;
  logic                  dq_oe_q, dq_oe_d;
  logic [BE_WIDTH-1:0]   be_n_q, be_n_d;
  logic                  oe_n_q, oe_n_d;
  logic                  we_n_q, we_n_d;
  logic                  ce_n_q, ce_n_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  perr_q, perr_d;
  logic                  accept;

  assign mm_waitrequest = reset | (state_q != ST_IDLE);
  assign accept         = (mm_read | mm_write) & ~mm_waitrequest;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    dq_out_d = dq_out_q;
    dq_oe_d  = dq_oe_q;
    be_n_d   = be_n_q;
    oe_n_d   = oe_n_q;
    we_n_d   = we_n_q;
    ce_n_d   = ce_n_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    perr_d   = perr_q;
    case (state_q)
      ST_IDLE: begin
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        ce_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        if (accept) begin
          addr_d = mm_address;
          if (mm_read) begin
            // A read always wins; a write raised alongside it is dropped and flagged.
            be_n_d  = '0;
            oe_n_d  = 1'b0;
            ce_n_d  = 1'b0;
            cnt_d   = 4'(READ_WAIT_CYCLES);
            state_d = ST_READ;
            if (mm_write) perr_d = 1'b1;
          end else begin
            be_n_d  = ~mm_byteenable;
            state_d = ST_WRITE;
            if (|mm_byteenable) begin
              we_n_d   = 1'b0;
              ce_n_d   = 1'b0;
              dq_oe_d  = 1'b1;
              dq_out_d = mm_writedata;
            end
          end
        end
      end
      ST_READ: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rdata_d  = sram_dq;
          rvalid_d = 1'b1;
          oe_n_d   = 1'b1;
          we_n_d   = 1'b1;
          ce_n_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_WRITE: begin
        dq_oe_d = 1'b0;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        ce_n_d  = 1'b1;
        be_n_d  = '1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      dq_oe_q  <= 1'b0;
      be_n_q   <= '1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      ce_n_q   <= 1'b1;
      cnt_q    <= 4'd0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      dq_oe_q  <= dq_oe_d;
      be_n_q   <= be_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      ce_n_q   <= ce_n_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      perr_q   <= perr_d;
    end
  end

  // Write data is only meaningful while dq_oe_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    dq_out_q <= dq_out_d;
  end

  assign sram_dq           = dq_oe_q ? dq_out_q : {DATA_WIDTH{1'bz}};
  assign sram_addr         = addr_q;
  assign sram_be_n         = be_n_q;
  assign sram_oe_n         = oe_n_q;
  assign sram_we_n         = we_n_q;
  assign sram_ce_n         = ce_n_q;
  assign mm_readdata       = rdata_q;
  assign mm_readdatavalid  = rvalid_q;
  assign mm_protocol_error = perr_q;

endmodule

// File: tb/tb_sram_pipelined_controller.sv
// Bench for sram_pipelined_controller: three instances (1, 0 and 3 read wait cycles),
// each attached to a behavioural asynchronous SRAM, plus an array reference of memory contents.
module tb_sram_pipelined_controller;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int BW = 2;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] mm_address [NI];
  logic          mm_read    [NI];
  logic          mm_write   [NI];
  logic [BW-1:0] mm_be      [NI];
  logic [DW-1:0] mm_wdata   [NI];
  logic          waitreq    [NI];
  logic [DW-1:0] rdata      [NI];
  logic          rvalid     [NI];
  logic          perr       [NI];
  logic [AW-1:0] s_addr     [NI];
  logic [BW-1:0] s_be_n     [NI];
  logic          s_oe_n     [NI];
  logic          s_we_n     [NI];
  logic          s_ce_n     [NI];
  logic [DW-1:0] s_dq       [NI];
  logic          bk_we      [NI];
  logic [11:0]   bk_addr    [NI];
  logic [DW-1:0] bk_data    [NI];
  int            viol       [NI] = '{0, 0, 0};

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [DW-1:0] refm [int];

  always @(posedge clk) cyc <= cyc + 1;

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : g_inst
      localparam int R = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
      wire  [DW-1:0] dq;
      logic [DW-1:0] mem [4096];

      sram_pipelined_controller #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_WAIT_CYCLES(R)
      ) dut (
        .clk(clk), .reset(rst),
        .mm_address(mm_address[g]), .mm_read(mm_read[g]), .mm_write(mm_write[g]),
        .mm_byteenable(mm_be[g]), .mm_writedata(mm_wdata[g]),
        .mm_waitrequest(waitreq[g]), .mm_readdata(rdata[g]),
        .mm_readdatavalid(rvalid[g]), .mm_protocol_error(perr[g]),
        .sram_addr(s_addr[g]), .sram_dq(dq), .sram_be_n(s_be_n[g]),
        .sram_oe_n(s_oe_n[g]), .sram_we_n(s_we_n[g]), .sram_ce_n(s_ce_n[g])
      );

      assign dq = (!s_ce_n[g] && !s_oe_n[g] && s_we_n[g]) ? mem[s_addr[g][11:0]] : {DW{1'bz}};
      assign s_dq[g] = dq;

      always @(negedge clk) begin
        if (bk_we[g]) begin
          mem[bk_addr[g]] <= bk_data[g];
        end else if (!s_ce_n[g] && !s_we_n[g]) begin
          for (int b = 0; b < BW; b++)
            if (!s_be_n[g][b]) mem[s_addr[g][11:0]][b*8 +: 8] <= dq[b*8 +: 8];
        end
        if (!s_oe_n[g] && !s_we_n[g]) viol[g] <= viol[g] + 1;
      end
    end
  endgenerate

  function automatic int rwc_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
  endfunction

  task automatic preload(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bk_addr[i] = a[11:0];
    bk_data[i] = d;
    bk_we[i]   = 1'b1;
    @(negedge clk);
    #1 bk_we[i] = 1'b0;
    if (i == 0) refm[int'(a)] = d;
  endtask

  // Drives one command, holds it until accepted; returns at #1 after the accepting edge.
  task automatic issue(input int i, input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] be, output int acc);
    logic w;
    mm_address[i] = a;
    mm_read[i]    = rd;
    mm_write[i]   = wr;
    mm_wdata[i]   = d;
    mm_be[i]      = be;
    acc = -1;
    for (int n = 0; n < 50; n++) begin
      w = waitreq[i];
      @(posedge clk);
      #1;
      if (!w) begin
        acc = cyc;
        break;
      end
    end
    mm_read[i]  = 1'b0;
    mm_write[i] = 1'b0;
    n_cmp++;
    if (acc < 0) begin
      n_fail++;
      $display("FAIL accept_timeout inst=%0d addr=%h: never accepted, required acceptance", i, a);
    end
    if (wr && !rd && i == 0)
      for (int b = 0; b < BW; b++)
        if (be[b]) refm[int'(a)][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic wait_rvalid(input int i, output int lat, output logic [DW-1:0] d);
    lat = -1;
    d   = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (rvalid[i]) begin
        lat = k;
        d   = rdata[i];
        break;
      end
    end
    n_cmp++;
    if (lat < 0) begin
      n_fail++;
      $display("FAIL rvalid_timeout inst=%0d: no readdatavalid, required one", i);
    end
  endtask

  task automatic test_reset();
    logic [43:0] obs, exp;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp = {1'b1, 20'h0, 3'b111, 2'b11, 1'b0, 16'h0, 1'b0};
    for (int i = 0; i < NI; i++) begin
      obs = {waitreq[i], s_addr[i], s_oe_n[i], s_we_n[i], s_ce_n[i], s_be_n[i],
             rvalid[i], rdata[i], perr[i]};
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset_state inst=%0d got=%h exp=%h", i, obs, exp);
      end
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      n_cmp++;
      if (waitreq[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL waitreq_after_reset inst=%0d got=%b exp=0", i, waitreq[i]);
      end
    end
  endtask

  task automatic test_read_basic();
    int acc, lat;
    logic [DW-1:0] d;
    logic [40:0] obs;
    preload(0, 20'h00123, 16'hBEEF);
    issue(0, 1'b1, 1'b0, 20'h00123, '0, '0, acc);
    obs = {s_oe_n[0], s_we_n[0], s_ce_n[0], s_be_n[0], s_addr[0], waitreq[0], 16'h0};
    n_cmp++;
    if (obs !== {3'b010, 2'b00, 20'h00123, 1'b1, 16'h0}) begin
      n_fail++;
      $display("FAIL read_pins got=%h exp=%h", obs, {3'b010, 2'b00, 20'h00123, 1'b1, 16'h0});
    end
    wait_rvalid(0, lat, d);
    n_cmp++;
    if (lat != 2 || d !== 16'hBEEF || waitreq[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL read_basic lat=%0d data=%h wr=%b exp lat=2 data=beef wr=0", lat, d, waitreq[0]);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (rvalid[0] !== 1'b0 || rdata[0] !== 16'hBEEF || s_oe_n[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL read_hold rvalid=%b data=%h oe_n=%b exp 0 beef 1", rvalid[0], rdata[0], s_oe_n[0]);
    end
  endtask

  task automatic test_write_partial();
    int acc, lat;
    logic [DW-1:0] d;
    preload(0, 20'h00010, 16'hABCD);
    issue(0, 1'b0, 1'b1, 20'h00010, 16'h1234, 2'b01, acc);
    n_cmp++;
    if ({s_we_n[0], s_ce_n[0], s_oe_n[0], s_be_n[0], s_dq[0], s_addr[0]} !==
        {3'b001, 2'b10, 16'h1234, 20'h00010}) begin
      n_fail++;
      $display("FAIL write_pins we=%b ce=%b oe=%b be_n=%b dq=%h addr=%h exp 0 0 1 10 1234 00010",
               s_we_n[0], s_ce_n[0], s_oe_n[0], s_be_n[0], s_dq[0], s_addr[0]);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({s_we_n[0], s_ce_n[0], s_be_n[0], waitreq[0]} !== {2'b11, 2'b11, 1'b0}) begin
      n_fail++;
      $display("FAIL write_release we=%b ce=%b be_n=%b wr=%b exp 1 1 11 0",
               s_we_n[0], s_ce_n[0], s_be_n[0], waitreq[0]);
    end
    issue(0, 1'b1, 1'b0, 20'h00010, '0, '0, acc);
    wait_rvalid(0, lat, d);
    n_cmp++;
    if (d !== 16'hAB34) begin
      n_fail++;
      $display("FAIL write_partial_readback got=%h exp=ab34", d);
    end
  endtask

  task automatic test_back_to_back();
    int a0, a1, a2, lat;
    logic [DW-1:0] d;
    issue(0, 1'b0, 1'b1, 20'h00020, 16'h5555, 2'b11, a0);
    issue(0, 1'b1, 1'b0, 20'h00010, '0, '0, a1);
    wait_rvalid(0, lat, d);
    issue(0, 1'b0, 1'b1, 20'h00021, 16'h6666, 2'b11, a2);
    n_cmp++;
    if (a1 - a0 != 2 || a2 - a0 != 5) begin
      n_fail++;
      $display("FAIL back_to_back accepts=+%0d,+%0d exp +2,+5", a1 - a0, a2 - a0);
    end
    n_cmp++;
    if (d !== 16'hAB34) begin
      n_fail++;
      $display("FAIL back_to_back_data got=%h exp=ab34", d);
    end
  endtask

  task automatic test_zero_be();
    int a0, a1, lat;
    logic [DW-1:0] d;
    preload(0, 20'h00030, 16'h7777);
    issue(0, 1'b0, 1'b1, 20'h00030, 16'h1111, 2'b00, a0);
    n_cmp++;
    if ({s_we_n[0], s_ce_n[0], waitreq[0]} !== 3'b111) begin
      n_fail++;
      $display("FAIL zero_be_pins we=%b ce=%b wr=%b exp 1 1 1", s_we_n[0], s_ce_n[0], waitreq[0]);
    end
    issue(0, 1'b1, 1'b0, 20'h00030, '0, '0, a1);
    wait_rvalid(0, lat, d);
    n_cmp++;
    if (a1 - a0 != 2 || d !== 16'h7777) begin
      n_fail++;
      $display("FAIL zero_be_effect gap=%0d data=%h exp gap=2 data=7777", a1 - a0, d);
    end
  endtask

  task automatic test_protocol_error();
    int acc, lat;
    logic [DW-1:0] d;
    preload(0, 20'h00040, 16'h4242);
    issue(0, 1'b1, 1'b1, 20'h00040, 16'hDEAD, 2'b11, acc);
    wait_rvalid(0, lat, d);
    n_cmp++;
    if (d !== 16'h4242 || perr[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL proto_err_read data=%h perr=%b exp 4242 1", d, perr[0]);
    end
    issue(0, 1'b1, 1'b0, 20'h00040, '0, '0, acc);
    wait_rvalid(0, lat, d);
    n_cmp++;
    if (d !== 16'h4242 || perr[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL proto_err_sticky data=%h perr=%b exp 4242 1", d, perr[0]);
    end
  endtask

  task automatic test_reset_abort();
    int acc;
    issue(0, 1'b1, 1'b0, 20'h00123, '0, '0, acc);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({rvalid[0], s_oe_n[0], s_we_n[0], s_ce_n[0], waitreq[0]} !== 5'b01111) begin
        n_fail++;
        $display("FAIL reset_abort cyc=%0d rv=%b oe=%b we=%b ce=%b wr=%b exp 0 1 1 1 1",
                 k, rvalid[0], s_oe_n[0], s_we_n[0], s_ce_n[0], waitreq[0]);
      end
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (waitreq[0] !== 1'b0 || perr[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release wr=%b perr=%b exp 0 0", waitreq[0], perr[0]);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (rvalid[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_no_pulse cyc=%0d rv=%b exp 0", k, rvalid[0]);
      end
    end
  endtask

  task automatic test_latency();
    int a0, a1, lat;
    logic [DW-1:0] d;
    for (int i = 1; i < NI; i++) begin
      preload(i, 20'h00055, 16'h0F00 + 16'(i));
      issue(i, 1'b1, 1'b0, 20'h00055, '0, '0, a0);
      wait_rvalid(i, lat, d);
      n_cmp++;
      if (lat != rwc_of(i) + 1 || d !== 16'h0F00 + 16'(i)) begin
        n_fail++;
        $display("FAIL latency inst=%0d lat=%0d data=%h exp lat=%0d data=%h",
                 i, lat, d, rwc_of(i) + 1, 16'h0F00 + 16'(i));
      end
      issue(i, 1'b1, 1'b0, 20'h00055, '0, '0, a1);
      wait_rvalid(i, lat, d);
      n_cmp++;
      if (a1 - a0 != rwc_of(i) + 2) begin
        n_fail++;
        $display("FAIL throughput inst=%0d gap=%0d exp=%0d", i, a1 - a0, rwc_of(i) + 2);
      end
    end
  endtask

  task automatic test_random();
    int acc, lat;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int k = 0; k < 32; k++) preload(0, AW'(k), DW'($urandom));
    for (int n = 0; n < 80; n++) begin
      a = AW'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 0) begin
        issue(0, 1'b0, 1'b1, a, DW'($urandom), BW'($urandom_range(0, 3)), acc);
      end else begin
        issue(0, 1'b1, 1'b0, a, '0, '0, acc);
        wait_rvalid(0, lat, d);
        n_cmp++;
        if (d !== refm[int'(a)]) begin
          n_fail++;
          $display("FAIL random_read addr=%h got=%h exp=%h", a, d, refm[int'(a)]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      mm_address[i] = '0;
      mm_read[i]    = 1'b0;
      mm_write[i]   = 1'b0;
      mm_be[i]      = '0;
      mm_wdata[i]   = '0;
      bk_we[i]      = 1'b0;
      bk_addr[i]    = '0;
      bk_data[i]    = '0;
    end
    test_reset();
    test_read_basic();
    test_write_partial();
    test_back_to_back();
    test_zero_be();
    test_protocol_error();
    test_reset_abort();
    test_latency();
    test_random();
    for (int i = 0; i < NI; i++) begin
      n_cmp++;
      if (viol[i] != 0) begin
        n_fail++;
        $display("FAIL dq_conflict inst=%0d cycles_with_oe_and_we_low=%0d exp=0", i, viol[i]);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
